// File: rtl/instruction_prefetch_queue_if.sv
// Bundle of fetch-side memory bus, datapath instruction handshake and redirect signals.
// master = prefetch queue side, slave = memory/datapath environment side.
interface instruction_prefetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             imem_request;
  logic [31:0]      imem_address;
  logic             imem_grant;
  logic             imem_valid;
  logic [31:0]      imem_data;
  logic             instruction_valid;
  logic             instruction_ready;
  logic [31:0]      instruction;
  logic [31:0]      instruction_pc;
  logic             redirect;
  logic [31:0]      redirect_target;
  logic [CNT_W-1:0] queue_count;

  modport master (
    output imem_request, imem_address,
    input  imem_grant, imem_valid, imem_data,
    output instruction_valid, instruction, instruction_pc,
    input  instruction_ready,
    input  redirect, redirect_target,
    output queue_count
  );

  modport slave (
    input  imem_request, imem_address,
    output imem_grant, imem_valid, imem_data,
    input  instruction_valid, instruction, instruction_pc,
    output instruction_ready,
    output redirect, redirect_target,
    input  queue_count
  );
endinterface

// File: rtl/instruction_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding fetch, DEPTH-entry {pc, insn} FIFO, redirect
// flush. Define PREFETCH_BYPASS_EN to forward a response straight to the datapath when empty.
module instruction_prefetch_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic                          clock,
  input logic                          reset,
  instruction_prefetch_queue_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef enum logic [1:0] {StFetch, StWait, StDiscard} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic              req_q, req_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       pc_mem   [DEPTH];
  logic [31:0]       data_mem [DEPTH];

  logic xfer, push, pop, head_valid, bypass_valid, bypass_take;
  logic unused_target_lsbs;

  assign unused_target_lsbs = ^bus.redirect_target[1:0];

  always_comb begin
    xfer       = req_q & bus.imem_grant;
    head_valid = (count_q != '0);
`ifdef PREFETCH_BYPASS_EN
    bypass_valid = (state_q == StWait) && !head_valid && bus.imem_valid && !bus.redirect;
`else
    bypass_valid = 1'b0;
`endif
    bypass_take = bypass_valid & bus.instruction_ready;
    push = (state_q == StWait) && bus.imem_valid && !bus.redirect && !bypass_take;
    pop  = head_valid && bus.instruction_ready && !bus.redirect;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_target[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      unique case (state_q)
        StFetch:   state_d = xfer ? StDiscard : StFetch;
        StWait:    state_d = bus.imem_valid ? StFetch : StDiscard;
        StDiscard: state_d = bus.imem_valid ? StFetch : StDiscard;
        default:   state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (xfer) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = StWait;
          end
        end
        StWait:    if (bus.imem_valid) state_d = StFetch;
        StDiscard: if (bus.imem_valid) state_d = StFetch;
        default:   state_d = StFetch;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
    // Request only when a slot is free for its response, so the queue can never overflow.
    req_d = (state_d == StFetch) && (count_d < Full);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_VECTOR;
      req_pc_q   <= RESET_VECTOR;
      req_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      req_q      <= req_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed through head_valid.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= req_pc_q;
      data_mem[wr_ptr_q] <= bus.imem_data;
    end
  end

  always_comb begin
    bus.imem_request      = req_q;
    bus.imem_address      = fetch_pc_q;
    bus.queue_count       = count_q;
    bus.instruction_valid = head_valid | bypass_valid;
    if (head_valid) begin
      bus.instruction    = data_mem[rd_ptr_q];
      bus.instruction_pc = pc_mem[rd_ptr_q];
    end else if (bypass_valid) begin
      bus.instruction    = bus.imem_data;
      bus.instruction_pc = req_pc_q;
    end else begin
      bus.instruction    = '0;
      bus.instruction_pc = '0;
    end
  end
endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed bench for instruction_prefetch_queue with a fixed-latency instruction memory model.
module tb_instruction_prefetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int LAT = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  instruction_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  instruction_prefetch_queue #(
    .DEPTH       (DEPTH),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          gcount = 0;
  logic [31:0] gaddr_q[$];
  bit          ovr_en = 1'b0;
  logic [31:0] data_override = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at negedge+1; samples the transfer just before posedge, updates memory at negedge.
  task automatic tick();
    #3;
    if (reset && bus.imem_request && bus.imem_grant) begin
      pend_cnt  = LAT;
      pend_addr = bus.imem_address;
      gcount++;
      gaddr_q.push_back(bus.imem_address);
    end
    #6;
    bus.imem_valid = 1'b0;
    bus.imem_data  = '0;
    if (!reset) pend_cnt = 0;
    else if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_data  = ovr_en ? data_override : {16'hC0DE, pend_addr[15:0]};
      end
    end
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = '0;
    ovr_en = 1'b0;
    gcount = 0;
    gaddr_q.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int i = 0;
    while (!bus.instruction_valid && i < max) begin
      tick();
      i++;
    end
    check({tag, " timeout"}, 32'(bus.instruction_valid), 32'd1);
  endtask

  task automatic wait_grants(input string tag, input int n, input int max);
    int i = 0;
    while (gcount < n && i < max) begin
      tick();
      i++;
    end
    check({tag, " grant timeout"}, 32'(gcount >= n), 32'd1);
  endtask

  initial begin
    bus.imem_grant        = 1'b1;
    bus.imem_valid        = 1'b0;
    bus.imem_data         = '0;
    bus.instruction_ready = 1'b1;
    bus.redirect          = 1'b0;
    bus.redirect_target   = '0;
    #1;
    check("rst req",   32'(bus.imem_request),      32'd0);
    check("rst addr",  bus.imem_address,           32'h0);
    check("rst valid", 32'(bus.instruction_valid), 32'd0);
    check("rst insn",  bus.instruction,            32'h0);
    check("rst pc",    bus.instruction_pc,         32'h0);
    check("rst count", 32'(bus.queue_count),       32'd0);

    // 1: sequential fetch, streaming consumer
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      wait_valid("t1 valid", 20);
      check("t1 pc",   bus.instruction_pc, 32'(4 * k));
      check("t1 insn", bus.instruction,    {16'hC0DE, 16'(4 * k)});
      tick();
    end
    check("t1 grant0", gaddr_q[0], 32'h0);
    check("t1 grant1", gaddr_q[1], 32'h4);
    check("t1 grant2", gaddr_q[2], 32'h8);

    // 2: stalled consumer fills the queue, then drains in order
    reset_dut();
    bus.instruction_ready = 1'b0;
    repeat (30) tick();
    check("t2 grants", 32'(gcount),            32'd4);
    check("t2 req",    32'(bus.imem_request),  32'd0);
    check("t2 count",  32'(bus.queue_count),   32'd4);
    bus.instruction_ready = 1'b1;
    gaddr_q.delete();
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t2 pop pc",   bus.instruction_pc, 32'(4 * k));
      check("t2 pop insn", bus.instruction,    {16'hC0DE, 16'(4 * k)});
      tick();
    end
    wait_grants("t2", 5, 10);
    check("t2 resume", (gaddr_q.size() > 0) ? gaddr_q[0] : 32'hFFFF_FFFF, 32'h10);

    // 3: redirect while waiting for a response
    reset_dut();
    wait_grants("t3", 1, 10);
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    check("t3 count", 32'(bus.queue_count),  32'd0);
    check("t3 req",   32'(bus.imem_request), 32'd0);
    wait_grants("t3", 2, 10);
    check("t3 addr",  gaddr_q[gaddr_q.size() - 1], 32'h0000_0100);
    wait_valid("t3 valid", 10);
    check("t3 pc",    bus.instruction_pc, 32'h0000_0100);
    check("t3 insn",  bus.instruction,    32'hC0DE_0100);

    // 4: redirect coincident with the grant of 0x8
    reset_dut();
    begin
      int i = 0;
      while (!(bus.imem_request && bus.imem_address == 32'h8) && i < 30) begin
        tick();
        i++;
      end
    end
    check("t4 req8", 32'(bus.imem_request && bus.imem_address == 32'h8), 32'd1);
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h0000_0200;
    tick();
    bus.redirect = 1'b0;
    check("t4 count", 32'(bus.queue_count), 32'd0);
    check("t4 fpc",   bus.imem_address,     32'h0000_0200);
    wait_valid("t4 valid", 15);
    check("t4 pc",    bus.instruction_pc,  32'h0000_0200);
    check("t4 insn",  bus.instruction,     32'hC0DE_0200);
    check("t4 grant", gaddr_q[gaddr_q.size() - 1], 32'h0000_0200);

    // 5: push and pop in one cycle, then asynchronous reset mid-wait
    reset_dut();
    bus.instruction_ready = 1'b0;
    begin
      int i = 0;
      while (!(bus.imem_valid && bus.queue_count == 3'd2) && i < 30) begin
        tick();
        i++;
      end
    end
    check("t5 setup", 32'(bus.imem_valid && bus.queue_count == 3'd2), 32'd1);
    bus.instruction_ready = 1'b1;
    tick();
    bus.instruction_ready = 1'b0;
    check("t5 count", 32'(bus.queue_count), 32'd2);
    check("t5 head",  bus.instruction_pc,   32'h4);
    wait_grants("t5", 4, 10);
    check("t5 waitv", 32'(bus.instruction_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5 async req",   32'(bus.imem_request),      32'd0);
    check("t5 async addr",  bus.imem_address,           32'h0);
    check("t5 async valid", 32'(bus.instruction_valid), 32'd0);
    check("t5 async insn",  bus.instruction,            32'h0);
    check("t5 async pc",    bus.instruction_pc,         32'h0);
    check("t5 async count", 32'(bus.queue_count),       32'd0);
    #7;

    // 6: empty queue, consumer ready, response forwarded or queued
    reset_dut();
    bus.instruction_ready = 1'b1;
    ovr_en = 1'b1;
    data_override = 32'hE3A0_0001;
    begin
      int i = 0;
      while (!bus.imem_valid && i < 10) begin
        tick();
        i++;
      end
    end
    check("t6 resp", 32'(bus.imem_valid), 32'd1);
`ifdef PREFETCH_BYPASS_EN
    check("t6 byp valid", 32'(bus.instruction_valid), 32'd1);
    check("t6 byp insn",  bus.instruction,            32'hE3A0_0001);
    check("t6 byp pc",    bus.instruction_pc,         32'h0);
    check("t6 byp count", 32'(bus.queue_count),       32'd0);
    tick();
    check("t6 post count", 32'(bus.queue_count),       32'd0);
    check("t6 post valid", 32'(bus.instruction_valid), 32'd0);
`else
    check("t6 nobyp valid", 32'(bus.instruction_valid), 32'd0);
    check("t6 nobyp insn",  bus.instruction,            32'h0);
    tick();
    check("t6 q valid", 32'(bus.instruction_valid), 32'd1);
    check("t6 q insn",  bus.instruction,            32'hE3A0_0001);
    check("t6 q count", 32'(bus.queue_count),       32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
